muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have a parameter: n, default 4, operand width in bits.
REQ-002 The block SHALL have an input port: clk, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have an input port: reset, 1 bit, synchronous, active-high.
REQ-004 The block SHALL have an input port: start, 1 bit, operation request, sampled only in IDLE.
REQ-005 The block SHALL have an input port: op, 2 bits; 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
REQ-006 The block SHALL have input ports: a and b, n bits each, unsigned operands (dividend/multiplicand a, divisor/multiplier b).
REQ-007 The block SHALL have an input port: rd_sel, 1 bit; 0 selects HI, 1 selects LO onto y.
REQ-008 The block SHALL have an output port: busy, 1 bit, high while an iterative operation runs.
REQ-009 The block SHALL have an output port: done, 1 bit, one-cycle pulse when a MULT/DIV result is in hi/lo.
REQ-010 The block SHALL have an output port: div0, 1 bit, high when the last accepted DIV had b = 0.
REQ-011 The block SHALL have output ports: hi and lo, n bits each, registered result pair.
REQ-012 The block SHALL have an output port: y, n bits, combinational read-back, rd_sel ? lo : hi.

Function
REQ-013 States SHALL be IDLE, MUL, DIV, DONE; busy = 1 exactly in MUL or DIV; done = 1 exactly in DONE.
REQ-014 In IDLE with start = 1 and op = MULT, the block SHALL capture a and b, clear the iteration count, and enter MUL.
REQ-015 In IDLE with start = 1, op = DIV and b != 0, the block SHALL capture the operands, clear div0 and the count, and enter DIV.
REQ-016 In IDLE with start = 1, op = DIV and b = 0, the block SHALL enter DONE on the next edge, set div0 = 1, hi = a, lo = all ones, with no iterations.
REQ-017 MTHI/MTLO with start = 1 in IDLE SHALL write a into hi (MTHI) or lo (MTLO) on that edge, stay in IDLE, and assert neither busy nor done.
REQ-018 MUL SHALL be shift-add, one multiplier bit per cycle, n iterations; the final product {hi,lo} = a*b (2n bits, unsigned, no overflow).
REQ-019 DIV SHALL be restoring division, one quotient bit per cycle, n iterations; final lo = a / b, hi = a % b (unsigned).
REQ-020 hi and lo SHALL NOT change during MUL/DIV; both are written on the edge of the n-th iteration, and that same edge enters DONE.
REQ-021 Latency SHALL be: done high in the cycle beginning n edges after the start edge; DONE lasts one cycle, then returns to IDLE.
REQ-022 start in MUL, DIV or DONE SHALL be ignored with no effect on operands, hi, lo or state; the requester re-issues it.
REQ-023 div0 SHALL hold its value until the next accepted MULT or DIV, which clears it (unless that DIV again has b = 0).
REQ-024 y SHALL reflect hi/lo combinationally in every state, including the pre-DONE values during busy.

Reset
REQ-025 When reset = 1 on a clock edge, the block SHALL set state = IDLE and hi = lo = 0, busy = done = div0 = 0, and clear the internal count/operand registers; this takes priority over all other inputs.
REQ-026 A reset during MUL/DIV SHALL abort the operation, with no partial result ever reaching hi/lo and no done pulse.

Verification (n = 4)
REQ-027 MULT a = 13, b = 11 -> busy for 4 cycles, then done pulse with hi = 0x8, lo = 0xF; rd_sel = 0 gives y = 0x8.
REQ-028 DIV a = 13, b = 4 -> done 4 cycles after start, lo = 3, hi = 1, div0 = 0.
REQ-029 DIV a = 15, b = 0 -> done on the next cycle, div0 = 1, hi = 0xF, lo = 0xF; a following MULT 2*3 clears div0 and gives hi = 0, lo = 6.
REQ-030 MTHI a = 0x5, then MTLO a = 0xA -> no busy/done; y = 0x5 with rd_sel = 0 and y = 0xA with rd_sel = 1.
REQ-031 Start MULT 15*15, issue start DIV 9/3 at cycle 2 -> the second request is ignored; result hi = 0xE, lo = 0x1.
REQ-032 Start DIV 14/3, assert reset at cycle 2 -> after the reset edge, all outputs are 0 and state is IDLE; a new MULT 3*3 gives lo = 9 four cycles later.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply/divide unit with a HI/LO result pair.
// MULT is shift-add and DIV is restoring division. Each takes n iterations,
// one bit per cycle. MTHI/MTLO load hi/lo directly in a single edge.
// A DIV by zero skips the iterations and flags div0.
module muldiv_seq #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         rd_sel,
  output logic         busy,
  output logic         done,
  output logic         div0,
  output logic [n-1:0] hi,
  output logic [n-1:0] lo,
  output logic [n-1:0] y
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state_q, state_d;
  logic [n-1:0]    a_q, a_d;      // multiplicand
  logic [n-1:0]    b_q, b_d;      // divisor
  logic [n-1:0]    acc_q, acc_d;  // partial product high half / partial remainder
  logic [n-1:0]    sh_q, sh_d;    // multiplier bits / dividend becoming quotient
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [n-1:0]    hi_q, hi_d;
  logic [n-1:0]    lo_q, lo_d;
  logic            div0_q, div0_d;

  // Shift-add step: add the multiplicand when the current multiplier bit is
  // set, then shift the {acc, sh} pair right by one.
  logic [n:0]      mul_sum;
  logic [n-1:0]    mul_acc, mul_sh;
  assign mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, a_q} : '0);
  assign mul_acc = mul_sum[n:1];
  assign mul_sh  = {mul_sum[0], sh_q[n-1:1]};

  // Restoring step: shift the next dividend bit into the remainder, and
  // subtract the divisor only if that leaves a non-negative value.
  // When it does, the result fits in n bits, so the subtraction can use
  // the low n bits alone.
  logic [n:0]      div_shift;
  logic            div_ge;
  logic [n-1:0]    div_rem, div_quo;
  assign div_shift = {acc_q, sh_q[n-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_rem   = div_ge ? (div_shift[n-1:0] - b_q) : div_shift[n-1:0];
  assign div_quo   = {sh_q[n-2:0], div_ge};

  logic last_iter;
  assign last_iter = (cnt_q == CW'(n - 1));

  // Next-state, datapath and status outputs.
  // NOTE: every signal this block drives is given a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div0_d  = div0_q;
    busy    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT: begin
              a_d     = a;
              sh_d    = b;
              acc_d   = '0;
              cnt_d   = '0;
              div0_d  = 1'b0;
              state_d = MUL;
            end
            OP_DIV: begin
              if (b == '0) begin
                hi_d    = a;
                lo_d    = '1;
                div0_d  = 1'b1;
                state_d = DONE;
              end else begin
                b_d     = b;
                sh_d    = a;
                acc_d   = '0;
                cnt_d   = '0;
                div0_d  = 1'b0;
                state_d = DIV;
              end
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      MUL: begin
        busy  = 1'b1;
        acc_d = mul_acc;
        sh_d  = mul_sh;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          hi_d    = mul_acc;
          lo_d    = mul_sh;
          state_d = DONE;
        end
      end
      DIV: begin
        busy  = 1'b1;
        acc_d = div_rem;
        sh_d  = div_quo;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          hi_d    = div_rem;
          lo_d    = div_quo;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, with synchronous reset taking priority.
  // NOTE: the operand and iteration registers are reset as well, not just the
  // visible results. An aborted operation then leaves no stale partial state.
  // The sequential block uses <= only, so every register samples the
  // pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div0_q  <= div0_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign div0 = div0_q;
  assign y    = rd_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (n = 4): directed scenarios followed by a
// randomized sequence of operations, checked against arithmetic expectations.
module tb_muldiv_seq;

  localparam int N   = 4;
  localparam int TMO = 40;

  localparam logic [1:0] MULT = 2'b00;
  localparam logic [1:0] DIVI = 2'b01;
  localparam logic [1:0] MTHI = 2'b10;
  localparam logic [1:0] MTLO = 2'b11;

  logic         clk = 1'b0;
  logic         reset, start, rd_sel;
  logic [1:0]   op;
  logic [N-1:0] a, b;
  logic         busy, done, div0;
  logic [N-1:0] hi, lo, y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rd_sel(rd_sel), .busy(busy), .done(done), .div0(div0),
    .hi(hi), .lo(lo), .y(y)
  );

  // Issue one request for a single cycle, then wait (bounded) for done.
  // lat counts the edges after the start edge until done is seen (-1 on
  // timeout). bcyc counts the busy cycles observed. stable drops if hi/lo
  // move before done.
  task automatic run_op(input logic [1:0] o, input logic [N-1:0] av, bv,
                        output int lat, output int bcyc, output bit stable);
    logic [N-1:0] hb, lb;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    hb = hi; lb = lo;
    @(negedge clk);
    start = 1'b0;
    lat = 0; bcyc = 0; stable = 1'b1;
    while (done !== 1'b1 && lat < TMO) begin
      if (busy === 1'b1) bcyc++;
      if (hi !== hb || lo !== lb) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (lat >= TMO) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = MULT; a = '0; b = '0; rd_sel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, div0} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b expected 000", {busy, done, div0});
    end
    checks++;
    if (hi !== '0 || lo !== '0 || y !== '0) begin
      errors++; $display("FAIL reset_hilo got hi=%h lo=%h y=%h expected 0 0 0", hi, lo, y);
    end
  endtask

  task automatic test_mult();
    int lat, bc; bit st;
    run_op(MULT, 4'd13, 4'd11, lat, bc, st);
    checks++;
    if (lat != N || bc != N || !st) begin
      errors++; $display("FAIL mult_timing got lat=%0d busy=%0d stable=%0d expected %0d %0d 1", lat, bc, st, N, N);
    end
    rd_sel = 1'b0; #1;
    checks++;
    if (hi !== 4'h8 || lo !== 4'hF || y !== 4'h8 || div0 !== 1'b0) begin
      errors++; $display("FAIL mult_13x11 got hi=%h lo=%h y=%h div0=%b expected 8 f 8 0", hi, lo, y, div0);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mult_done_pulse got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_div();
    int lat, bc; bit st;
    run_op(DIVI, 4'd13, 4'd4, lat, bc, st);
    checks++;
    if (lat != N || bc != N || !st) begin
      errors++; $display("FAIL div_timing got lat=%0d busy=%0d stable=%0d expected %0d %0d 1", lat, bc, st, N, N);
    end
    checks++;
    if (lo !== 4'd3 || hi !== 4'd1 || div0 !== 1'b0) begin
      errors++; $display("FAIL div_13_4 got hi=%h lo=%h div0=%b expected 1 3 0", hi, lo, div0);
    end
    @(negedge clk);
  endtask

  task automatic test_div0();
    int lat, bc; bit st;
    run_op(DIVI, 4'd15, 4'd0, lat, bc, st);
    checks++;
    if (lat != 0 || bc != 0) begin
      errors++; $display("FAIL div0_timing got lat=%0d busy=%0d expected 0 0", lat, bc);
    end
    checks++;
    if (div0 !== 1'b1 || hi !== 4'hF || lo !== 4'hF) begin
      errors++; $display("FAIL div0_result got div0=%b hi=%h lo=%h expected 1 f f", div0, hi, lo);
    end
    @(negedge clk);
    checks++;
    if (div0 !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL div0_hold got div0=%b done=%b expected 1 0", div0, done);
    end
    run_op(MULT, 4'd2, 4'd3, lat, bc, st);
    checks++;
    if (lat != N || div0 !== 1'b0 || hi !== 4'd0 || lo !== 4'd6) begin
      errors++; $display("FAIL div0_clear got lat=%0d div0=%b hi=%h lo=%h expected %0d 0 0 6", lat, div0, hi, lo, N);
    end
    @(negedge clk);
  endtask

  task automatic test_moves();
    @(negedge clk);
    op = MTHI; a = 4'h5; b = 4'h0; start = 1'b1;
    @(negedge clk);
    op = MTLO; a = 4'hA;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 4'h5) begin
      errors++; $display("FAIL mthi got busy=%b done=%b hi=%h expected 0 0 5", busy, done, hi);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || lo !== 4'hA) begin
      errors++; $display("FAIL mtlo got busy=%b done=%b lo=%h expected 0 0 a", busy, done, lo);
    end
    rd_sel = 1'b0; #1;
    checks++;
    if (y !== 4'h5) begin
      errors++; $display("FAIL y_hi got %h expected 5", y);
    end
    rd_sel = 1'b1; #1;
    checks++;
    if (y !== 4'hA) begin
      errors++; $display("FAIL y_lo got %h expected a", y);
    end
    rd_sel = 1'b0;
  endtask

  task automatic test_ignore_start();
    int k;
    logic [N-1:0] hb, lb;
    bit seen_busy_y;
    @(negedge clk);
    op = MULT; a = 4'd15; b = 4'd15; start = 1'b1;
    hb = hi; lb = lo;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op = DIVI; a = 4'd9; b = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 2;
    seen_busy_y = 1'b1;
    while (done !== 1'b1 && k < TMO) begin
      rd_sel = 1'b1; #1;
      if (y !== lb) seen_busy_y = 1'b0;
      rd_sel = 1'b0; #1;
      if (y !== hb) seen_busy_y = 1'b0;
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != N || !seen_busy_y) begin
      errors++; $display("FAIL ignore_timing got lat=%0d y_prior=%0d expected %0d 1", k, seen_busy_y, N);
    end
    checks++;
    if (hi !== 4'hE || lo !== 4'h1) begin
      errors++; $display("FAIL ignore_result got hi=%h lo=%h expected e 1", hi, lo);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 4'hE) begin
      errors++; $display("FAIL ignore_no_div got busy=%b done=%b hi=%h expected 0 0 e", busy, done, hi);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc; bit st;
    bit pulse;
    @(negedge clk);
    op = DIVI; a = 4'd14; b = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_sel = 1'b0; #1;
    checks++;
    if ({busy, done, div0} !== 3'b000 || hi !== '0 || lo !== '0 || y !== '0) begin
      errors++; $display("FAIL abort_clear got flags=%b hi=%h lo=%h y=%h expected 000 0 0 0", {busy, done, div0}, hi, lo, y);
    end
    pulse = 1'b0;
    repeat (N + 2) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || hi !== '0 || lo !== '0) pulse = 1'b1;
    end
    checks++;
    if (pulse) begin
      errors++; $display("FAIL abort_quiet got activity=1 expected 0");
    end
    run_op(MULT, 4'd3, 4'd3, lat, bc, st);
    checks++;
    if (lat != N || hi !== 4'd0 || lo !== 4'd9) begin
      errors++; $display("FAIL abort_mult got lat=%0d hi=%h lo=%h expected %0d 0 9", lat, hi, lo, N);
    end
    @(negedge clk);
  endtask

  // Random operation mix checked against plain integer arithmetic.
  task automatic test_random();
    int lat, bc, elat; bit st;
    int unsigned mh, ml, prod;
    bit md0;
    logic [1:0] o;
    logic [N-1:0] av, bv;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mh = 0; ml = 0; md0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      o  = 2'($urandom_range(0, 3));
      av = N'($urandom_range(0, 15));
      bv = N'($urandom_range(0, 15));
      if (i % 7 == 0) bv = '0;
      if (o == MULT || o == DIVI) begin
        if (o == MULT) begin
          prod = av * bv;
          mh = (prod >> N) % 16; ml = prod % 16; md0 = 1'b0; elat = N;
        end else if (bv == 0) begin
          mh = av; ml = 15; md0 = 1'b1; elat = 0;
        end else begin
          mh = av % bv; ml = av / bv; md0 = 1'b0; elat = N;
        end
        run_op(o, av, bv, lat, bc, st);
        checks++;
        if (lat != elat || bc != elat || !st) begin
          errors++; $display("FAIL rnd_timing op=%0d a=%0d b=%0d got lat=%0d busy=%0d stable=%0d expected %0d %0d 1", o, av, bv, lat, bc, st, elat, elat);
        end
        @(negedge clk);
      end else begin
        if (o == MTHI) mh = av; else ml = av;
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          errors++; $display("FAIL rnd_move_flags op=%0d got busy=%b done=%b expected 0 0", o, busy, done);
        end
      end
      rd_sel = 1'($urandom_range(0, 1)); #1;
      checks++;
      if (hi !== N'(mh) || lo !== N'(ml) || div0 !== md0 || y !== (rd_sel ? N'(ml) : N'(mh))) begin
        errors++; $display("FAIL rnd_result op=%0d a=%0d b=%0d got hi=%h lo=%h div0=%b y=%h expected %h %h %b sel=%b", o, av, bv, hi, lo, div0, y, N'(mh), N'(ml), md0, rd_sel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_moves();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
